srff_driver: RTL and testbench
==============================

# srff_driver

Sequential driver for a bank of `WIDTH` clocked SR flip-flops; it turns a stream of desired Q values into legal per-bit S/R excitations.
- Accepts target words on a valid/ready handshake and tracks a model of the bank's state.
- Emits one cycle of S/R per word and never drives S=R=1.
- Checks the bank's Q/Q' feedback one cycle later and counts mismatches.
- Sits between control logic and any SR-flop register bank in the design.

## Interface
- `WIDTH`, 4: number of SR flip-flops driven.
- `ERRW`, 8: width of the saturating error counter.

- `clk`  in  1  rising-edge clock shared with the driven SR bank.
- `rst`  in  1  reset; synchronous, active-high.
- `tgt`  in  WIDTH  desired Q value for the bank.
- `tgt_valid`  in  1  `tgt` is valid.
- `tgt_ready`  out  1  driver can accept a target word (high only in IDLE).
- `s`  out  WIDTH  set lines to the bank (registered).
- `r`  out  WIDTH  reset lines to the bank (registered).
- `q_fb`  in  WIDTH  bank Q outputs.
- `q1_fb`  in  WIDTH  bank complementary outputs.
- `q_model`  out  WIDTH  driver's model of bank state (registered).
- `done`  out  1  one-cycle pulse: a word has been applied and checked.
- `err`  out  1  one-cycle pulse, coincident with `done`: the check failed.
- `err_count`  out  ERRW  saturating count of failed checks.

## Operation
- The state machine has four states: CLEAR, IDLE, APPLY and CHECK.
- **Reset.** While `rst` is high, every edge loads:
  - state = CLEAR, `s` = 0, `r` = all ones;
  - `q_model` = 0, `done` = 0, `err` = 0, `err_count` = 0.
- **CLEAR.** Forces the bank to 0.
  - The first edge after `rst` falls goes to IDLE and loads `r` = 0.
- **IDLE.** `tgt_ready` = 1 and `s` = `r` = 0.
  - On an edge with `tgt_valid` = 1: go to APPLY, capture `tgt` into a target register, and load `s`/`r` from the excitation of (`q_model`, `tgt`).
- **Per-bit excitation.**
  - 0→0: s=0, r=0.
  - 0→1: s=1, r=0.
  - 1→0: s=0, r=1.
  - 1→1: s=0, r=0.
  - s=r=1 is never produced. This invariant holds in every state and during reset.
- **APPLY.** `s`/`r` are presented for exactly one cycle; the bank samples them on the next edge.
  - Next edge: go to CHECK and load `s` = `r` = 0.
- **CHECK.** The check fails if `q_fb` ≠ target register, or if `q1_fb` ≠ ~`q_fb`. Both are compared combinationally.
  - Next edge: go to IDLE and pulse `done`.
  - Pass: `q_model` ← target register.
  - Fail: `q_model` ← `q_fb` (the actual bank state), `err` pulses, and `err_count` increments, saturating at 2^ERRW−1.
- A target equal to `q_model` still runs the full APPLY/CHECK sequence with all-zero excitation. This re-verifies the bank.
- `tgt` and `tgt_valid` are ignored outside IDLE.

## Timing
- Accept at edge E0, then:
  - `s`/`r` valid in the cycle after E0;
  - bank updates at E1;
  - check sampled at E2;
  - `done`/`err`/`q_model` visible after E2, together with `tgt_ready` = 1.
- Throughput: one word per 3 cycles. The earliest next accept is at E3.
- Reset mid-operation: reset takes priority on the same edge from any state.
  - Any pending word is dropped with no `done`.
  - `err_count` is cleared.
  - The bank is re-cleared through CLEAR.
- `err_count` at maximum: a further failure still pulses `err`; the count holds.

## Structure
- The package `srff_pkg` holds:
  - the state enum (CLEAR, IDLE, APPLY, CHECK);
  - the encoding constants for a 2-bit SR pair (HOLD=00, RESET=01, SET=10, ILLEGAL=11);
  - the default `WIDTH`/`ERRW`.
- The sub-module `srff_excite` is the per-bit excitation. It is purely combinational: inputs (q_cur, q_next), outputs (s, r). It is instantiated WIDTH times via generate.
- FSM, registers and checker live in `srff_driver`.
- The bench drives a model bank of `srff` instances from `s`/`r`, feeding `q_fb`/`q1_fb` back.

## Test plan
- **Reset:** hold `rst` 2 cycles → `r`=1111, `s`=0000, bank Q=0000. First edge after release → `r`=0000, `tgt_ready`=1.
- **Set bits:** from `q_model`=0000, `tgt`=1010 → APPLY cycle shows `s`=1010, `r`=0000. `done` 2 cycles later with `err`=0 and `q_model`=1010.
- **Mixed and no-op:** from 1010, `tgt`=0110 → `s`=0100, `r`=1000. Then `tgt`=0110 again → `s`=`r`=0000, `done` with no error.
- **Forced fault:** force bank bit 0 stuck at 0, then `tgt`=0001 → `err` pulses with `done`, `err_count`=1, `q_model`=0000. Also break `q1_fb` so it is not ~`q_fb` → `err` pulses.
- **Saturation:** with `ERRW`=2, force 5 failures → `err_count` stops at 3 and `err` pulses all 5 times.
- **Reset in APPLY:** assert `rst` during APPLY → no `done`; next cycle `r`=1111 and `err_count`=0. Assert S&R continuously, which must never fire.

Source files
------------

// File: rtl/srff_pkg.sv
// Shared types and constants for the SR flip-flop bank driver.
package srff_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_APPLY = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  // SR pair encoding, packed as {s, r}
  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_RESET   = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_ILLEGAL = 2'b11;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_ERRW  = 8;

endpackage

// File: rtl/srff_excite.sv
// Per-bit SR excitation: purely combinational; never produces s=r=1.
module srff_excite
  import srff_pkg::*;
(
  input  logic q_cur,
  input  logic q_next,
  output logic s,
  output logic r
);

  logic [1:0] sr;

  always_comb begin
    sr = SR_HOLD;
    case ({q_cur, q_next})
      2'b01:   sr = SR_SET;
      2'b10:   sr = SR_RESET;
      default: sr = SR_HOLD;
    endcase
  end

  assign s = sr[1];
  assign r = sr[0];

endmodule

// File: rtl/srff_driver.sv
// Drives an SR flop bank from target words; accept-to-done latency 2 edges, one word per 3 cycles.
// Backpressure: tgt_ready is high only in IDLE; tgt/tgt_valid are ignored otherwise.
module srff_driver
  import srff_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ERRW  = DEF_ERRW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tgt,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q_fb,
  input  logic [WIDTH-1:0] q1_fb,
  output logic [WIDTH-1:0] q_model,
  output logic             done,
  output logic             err,
  output logic [ERRW-1:0]  err_count
);

  state_t state, state_nxt;

  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] exc_s, exc_r;
  logic [WIDTH-1:0] s_d, r_d, q_model_d;
  logic [ERRW-1:0]  cnt_d;
  logic             done_d, err_d;
  logic             chk_fail;

  for (genvar i = 0; i < WIDTH; i++) begin : g_exc
    srff_excite u_exc (
      .q_cur  (q_model[i]),
      .q_next (tgt[i]),
      .s      (exc_s[i]),
      .r      (exc_r[i])
    );
  end

  // Bank must match the target and its two outputs must be complementary
  assign chk_fail = (q_fb != tgt_q) || (q1_fb != ~q_fb);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: state_nxt = ST_IDLE;
      ST_IDLE:  if (tgt_valid) state_nxt = ST_APPLY;
      ST_APPLY: state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = ST_IDLE;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  always_comb begin
    tgt_ready = (state == ST_IDLE);
    s_d       = '0;
    r_d       = '0;
    tgt_d     = tgt_q;
    q_model_d = q_model;
    cnt_d     = err_count;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tgt_valid) begin
          s_d   = exc_s;
          r_d   = exc_r;
          tgt_d = tgt;
        end
      end
      ST_CHECK: begin
        done_d = 1'b1;
        if (chk_fail) begin
          err_d     = 1'b1;
          q_model_d = q_fb;
          if (err_count != {ERRW{1'b1}}) cnt_d = err_count + 1'b1;
        end else begin
          q_model_d = tgt_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= '0;
      r         <= '1;
      tgt_q     <= '0;
      q_model   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      s         <= s_d;
      r         <= r_d;
      tgt_q     <= tgt_d;
      q_model   <= q_model_d;
      done      <= done_d;
      err       <= err_d;
      err_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_srff_driver.sv
// Bench: behavioural SR bank with fault injection, cycle model compared every cycle, directed literal checks.
module tb_srff_driver;

  localparam int W  = 4;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  tgt = '0;
  logic          tgt_valid = 1'b0;
  logic          tgt_ready;
  logic [W-1:0]  s, r, q_fb, q1_fb, q_model;
  logic          done, err;
  logic [EW-1:0] err_count;

  logic [W-1:0]  bank    = 4'b1111;
  logic [W-1:0]  stuck0  = '0;
  logic [W-1:0]  q1_flip = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  srff_driver #(.WIDTH(W), .ERRW(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt       (tgt),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .s         (s),
    .r         (r),
    .q_fb      (q_fb),
    .q1_fb     (q1_fb),
    .q_model   (q_model),
    .done      (done),
    .err       (err),
    .err_count (err_count)
  );

  // Behavioural SR bank; stuck0 pins bits low, q1_flip corrupts the complement output
  always_ff @(posedge clk) bank <= ((bank | s) & ~r) & ~stuck0;
  assign q_fb  = bank;
  assign q1_fb = ~bank ^ q1_flip;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: a word occupies the driver for 3 edges after acceptance
  logic          m_init = 1'b0;
  int            m_wait = 0;
  logic          m_pend = 1'b0;
  logic [W-1:0]  m_tgt = '0, m_qm = '0, exp_s = '0, exp_r = '0;
  logic          exp_done = 1'b0, exp_err = 1'b0;
  int            m_cnt = 0;

  always @(posedge clk) begin
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_s    = '0;
    exp_r    = '0;
    if (rst) begin
      m_init = 1'b1;
      m_wait = 1;
      m_pend = 1'b0;
      m_qm   = '0;
      m_cnt  = 0;
      exp_r  = '1;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0 && m_pend) begin
        m_pend   = 1'b0;
        exp_done = 1'b1;
        if (q_fb != m_tgt || q1_fb != ~q_fb) begin
          exp_err = 1'b1;
          m_qm    = q_fb;
          if (m_cnt < (1 << EW) - 1) m_cnt++;
        end else begin
          m_qm = m_tgt;
        end
      end
    end else if (tgt_valid) begin
      m_tgt  = tgt;
      exp_s  = tgt & ~m_qm;
      exp_r  = ~tgt & m_qm;
      m_wait = 2;
      m_pend = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("s", s, exp_s);
      check("r", r, exp_r);
      check("tgt_ready", tgt_ready, m_wait == 0);
      check("done", done, exp_done);
      check("err", err, exp_err);
      check("q_model", q_model, m_qm);
      check("err_count", err_count, m_cnt);
    end
    check("no_s_and_r", s & r, 0);
  end

  task automatic wait_ready();
    int n = 0;
    while (!tgt_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", tgt_ready, 1);
  endtask

  task automatic send(input logic [W-1:0] v, input logic [W-1:0] es, input logic [W-1:0] er,
                      input logic e_err, input logic [W-1:0] eqm, input int ecnt);
    wait_ready();
    tgt = v;
    tgt_valid = 1'b1;
    @(negedge clk);
    tgt_valid = 1'b0;
    check("lit_apply_s", s, es);
    check("lit_apply_r", r, er);
    @(negedge clk);
    check("lit_check_nodone", done, 0);
    @(negedge clk);
    check("lit_done", done, 1);
    check("lit_err", err, e_err);
    check("lit_q_model", q_model, eqm);
    check("lit_err_count", err_count, ecnt);
    check("lit_ready", tgt_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_r", r, 4'b1111);
    check("rst_s", s, 4'b0000);
    check("rst_bank", bank, 4'b0000);
    rst = 1'b0;
    @(negedge clk);
    check("clear_r", r, 4'b0000);
    check("clear_ready", tgt_ready, 1);

    send(4'b1010, 4'b1010, 4'b0000, 1'b0, 4'b1010, 0);
    send(4'b0110, 4'b0100, 4'b1000, 1'b0, 4'b0110, 0);
    send(4'b0110, 4'b0000, 4'b0000, 1'b0, 4'b0110, 0);

    stuck0 = 4'b0001;
    send(4'b0001, 4'b0001, 4'b0110, 1'b1, 4'b0000, 1);
    stuck0 = 4'b0000;

    q1_flip = 4'b0100;
    send(4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2);
    send(4'b0011, 4'b0011, 4'b0000, 1'b1, 4'b0011, 3);
    send(4'b0011, 4'b0000, 4'b0000, 1'b1, 4'b0011, 3);
    send(4'b1100, 4'b1100, 4'b0011, 1'b1, 4'b1100, 3);
    q1_flip = 4'b0000;

    wait_ready();
    tgt = 4'b0101;
    tgt_valid = 1'b1;
    @(negedge clk);
    tgt_valid = 1'b0;
    check("abort_apply_s", s, 4'b0001);
    rst = 1'b1;
    @(negedge clk);
    check("abort_r", r, 4'b1111);
    check("abort_s", s, 4'b0000);
    check("abort_done", done, 0);
    check("abort_err_count", err_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", tgt_ready, 1);
    check("abort_bank", bank, 4'b0000);

    send(4'b1111, 4'b1111, 4'b0000, 1'b0, 4'b1111, 0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
